// File: rtl/ivideo_align_pkg.sv
// Shared types and constants for the IVIDEO 1:7 word-alignment controller.
package ivideo_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    localparam logic [6:0] DEF_PATTERN = 7'b1100011;
    localparam int         CNT_W       = 8;
    localparam int         SLIP_W      = 4;

endpackage

// File: rtl/ivideo_align_ctl_if.sv
// Control/status bundle between the alignment controller and the deserializer side.
interface ivideo_align_ctl_if;
    import ivideo_align_pkg::*;

    logic              start_i;
    logic [6:0]        q_i;
    logic              calib_o;
    logic              busy_o;
    logic              locked_o;
    logic              fail_o;
    logic [SLIP_W-1:0] slip_cnt_o;

    modport master (
        output start_i, q_i,
        input  calib_o, busy_o, locked_o, fail_o, slip_cnt_o
    );

    modport slave (
        input  start_i, q_i,
        output calib_o, busy_o, locked_o, fail_o, slip_cnt_o
    );

endinterface

// File: rtl/ivideo_align_ctl.sv
// Bit-slip word aligner: pulses CALIB until PATTERN is seen MATCH_CYC times in a row,
// then monitors the lock and re-aligns after LOSS_THR consecutive mismatches.
module ivideo_align_ctl
    import ivideo_align_pkg::*;
#(
    parameter logic [6:0] PATTERN    = DEF_PATTERN,
    parameter int         SETTLE_CYC = 8,
    parameter int         MATCH_CYC  = 16,
    parameter int         MAX_SLIPS  = 13,
    parameter int         CALIB_LEN  = 1,
    parameter int         LOSS_THR   = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    ivideo_align_ctl_if.slave  bus
);

    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  MATCH_LD  = CNT_W'(MATCH_CYC - 1);
    localparam logic [CNT_W-1:0]  CALIB_LD  = CNT_W'(CALIB_LEN - 1);
    localparam logic [CNT_W-1:0]  LOSS_LIM  = CNT_W'(LOSS_THR);
    localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(MAX_SLIPS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    loss_q, loss_d;
    logic [CNT_W-1:0]    loss_inc;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic                calib_q, calib_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic                fail_q, fail_d;
    logic                match;

    assign match    = (bus.q_i == PATTERN);
    assign loss_inc = (loss_q == {CNT_W{1'b1}}) ? loss_q : loss_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = '0;
        slip_d  = slip_q;

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (bus.start_i) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    slip_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    cnt_d   = MATCH_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (match) begin
                    if (cnt_q == '0) state_d = ST_LOCKED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end else if (slip_q < SLIP_MAX) begin
                    // slip_q < SLIP_MAX guarantees the increment cannot pass the cap
                    state_d = ST_SLIP;
                    cnt_d   = CALIB_LD;
                    slip_d  = slip_q + SLIP_W'(1);
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_SLIP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (bus.start_i) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    slip_d  = '0;
                end else if (!match) begin
                    if (loss_inc >= LOSS_LIM) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LD;
                        slip_d  = '0;
                    end else begin
                        loss_d = loss_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered copies decoded from the next state
        calib_d  = (state_d == ST_SLIP);
        busy_d   = (state_d == ST_SETTLE) || (state_d == ST_CHECK) || (state_d == ST_SLIP);
        locked_d = (state_d == ST_LOCKED);
        fail_d   = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            loss_q   <= '0;
            slip_q   <= '0;
            calib_q  <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loss_q   <= loss_d;
            slip_q   <= slip_d;
            calib_q  <= calib_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.calib_o    = calib_q;
    assign bus.busy_o     = busy_q;
    assign bus.locked_o   = locked_q;
    assign bus.fail_o     = fail_q;
    assign bus.slip_cnt_o = slip_q;

endmodule

// File: tb/tb_ivideo_align_ctl.sv
// Bench for ivideo_align_ctl: a rotating-word deserializer model driven by calib_o,
// with expected timing computed from the alignment rules (settle/slip/match arithmetic).
module tb_ivideo_align_ctl;

    localparam logic [6:0] PAT    = 7'b1100011;
    localparam int         SETTLE = 8;
    localparam int         MATCH  = 16;
    localparam int         MAXS   = 13;
    localparam int         CAL    = 1;
    localparam int         LOSS   = 4;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    ivideo_align_ctl_if bus ();

    ivideo_align_ctl dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int phase = 0;

    function automatic logic [6:0] rotl(input logic [6:0] v, input int n);
        logic [6:0] r;
        r = v;
        for (int i = 0; i < (n % 7); i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    function automatic logic [6:0] mis_word();
        logic [6:0] w;
        do w = 7'($urandom); while (w == PAT);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then follow the deserializer model until lock or budget expiry.
    task automatic align_run(input int r, output int lock_c, output int npulse, output int nhigh);
        logic prev;
        prev   = 1'b0;
        phase  = r;
        npulse = 0;
        nhigh  = 0;
        lock_c = -1;
        bus.q_i     = rotl(PAT, phase);
        bus.start_i = 1'b1;
        cyc = 0;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 400 && lock_c < 0; i++) begin
            if (bus.calib_o) begin
                nhigh++;
                if (!prev) npulse++;
                phase = (phase + 1) % 7;
            end
            prev = bus.calib_o;
            if (bus.locked_o) lock_c = cyc;
            else begin
                bus.q_i = rotl(PAT, phase);
                tick();
            end
        end
    endtask

    int lc, np, nh, r, s, k, fc, relock;
    logic prev_c;

    initial begin
        rst_i       = 1'b1;
        bus.start_i = 1'b0;
        bus.q_i     = '0;
        tick();
        tick();
        chk("rst_calib",  bus.calib_o,    0);
        chk("rst_busy",   bus.busy_o,     0);
        chk("rst_locked", bus.locked_o,   0);
        chk("rst_fail",   bus.fail_o,     0);
        chk("rst_slip",   bus.slip_cnt_o, 0);
        rst_i = 1'b0;
        tick();
        chk("idle_busy", bus.busy_o, 0);

        // Aligned input
        align_run(0, lc, np, nh);
        chk("aligned_lock_cyc", lc, SETTLE + MATCH + 1);
        chk("aligned_slip",     bus.slip_cnt_o, 0);
        chk("aligned_calib",    nh, 0);
        chk("aligned_busy",     bus.busy_o, 0);

        // Misaligned runs (first one is 3 slips away), each followed by a loss/relock
        for (int it = 0; it < 4; it++) begin
            r = (it == 0) ? 4 : $urandom_range(6, 1);
            s = (7 - r) % 7;
            align_run(r, lc, np, nh);
            chk("mis_lock_cyc", lc, SETTLE + 1 + s * (1 + CAL + SETTLE) + MATCH);
            chk("mis_pulses",   np, s);
            chk("mis_high_cyc", nh, s * CAL);
            chk("mis_slip",     bus.slip_cnt_o, s);
            chk("mis_busy",     bus.busy_o, 0);

            k = $urandom_range(LOSS - 1, 1);
            for (int j = 0; j < k; j++) begin
                bus.q_i = mis_word();
                tick();
                chk("hold_mis", bus.locked_o, 1);
            end
            bus.q_i = PAT;
            tick();
            chk("hold_match", bus.locked_o, 1);
            for (int j = 0; j < LOSS; j++) begin
                bus.q_i = mis_word();
                tick();
                chk("loss_locked", bus.locked_o, (j == LOSS - 1) ? 0 : 1);
            end
            chk("loss_busy", bus.busy_o, 1);
            chk("loss_slip", bus.slip_cnt_o, 0);
            bus.q_i = PAT;
            relock  = 0;
            for (int n = 0; n < 100 && !bus.locked_o; n++) begin
                tick();
                relock++;
            end
            chk("relock_cyc", relock, SETTLE + MATCH);
        end

        // Never aligns
        bus.q_i     = '0;
        bus.start_i = 1'b1;
        cyc = 0;
        tick();
        bus.start_i = 1'b0;
        fc = -1;
        np = 0;
        prev_c = 1'b0;
        for (int n = 0; n < 300 && fc < 0; n++) begin
            if (bus.calib_o && !prev_c) np++;
            prev_c = bus.calib_o;
            if (bus.fail_o) fc = cyc;
            else tick();
        end
        chk("fail_cyc",    fc, SETTLE + 1 + MAXS * (1 + CAL + SETTLE) + 1);
        chk("fail_pulses", np, MAXS);
        chk("fail_slip",   bus.slip_cnt_o, MAXS);
        chk("fail_busy",   bus.busy_o, 0);
        chk("fail_locked", bus.locked_o, 0);
        nh = 0;
        for (int n = 0; n < 20; n++) begin
            bus.q_i = 7'($urandom);
            tick();
            if (bus.calib_o) nh++;
        end
        chk("fail_sticky",  bus.fail_o, 1);
        chk("fail_nocalib", nh, 0);

        // Restart from FAIL, then reset during the first calib pulse
        bus.q_i     = '0;
        bus.start_i = 1'b1;
        cyc = 0;
        tick();
        bus.start_i = 1'b0;
        chk("restart_fail", bus.fail_o, 0);
        chk("restart_busy", bus.busy_o, 1);
        chk("restart_slip", bus.slip_cnt_o, 0);
        for (int n = 0; n < 50 && !bus.calib_o; n++) tick();
        chk("first_calib_cyc", cyc, SETTLE + 2);
        rst_i = 1'b1;
        tick();
        chk("midslip_calib",  bus.calib_o,    0);
        chk("midslip_busy",   bus.busy_o,     0);
        chk("midslip_locked", bus.locked_o,   0);
        chk("midslip_fail",   bus.fail_o,     0);
        chk("midslip_slip",   bus.slip_cnt_o, 0);

        // Reset wins over a simultaneous start
        bus.start_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        bus.start_i = 1'b0;
        tick();
        chk("rst_over_start", bus.busy_o, 0);

        // start during SETTLE must not restart the settle window
        bus.start_i = 1'b1;
        cyc = 0;
        tick();
        bus.start_i = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int n = 0; n < 50 && !bus.calib_o; n++) tick();
        chk("settle_start_ignored", cyc, SETTLE + 2);
        chk("settle_start_slip",    bus.slip_cnt_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ivideo_align_ctl.md
# ivideo_align_ctl

Word-alignment controller for the 1:7 IVIDEO input deserializer. It runs in the deserializer's parallel-clock domain and watches the 7-bit parallel word. It pulses the deserializer's CALIB (bit-slip) input until a known training pattern appears stably, then reports lock. While locked it keeps monitoring and re-aligns itself after sustained pattern loss.

## Interface
Parameters:
- PATTERN, 7'b1100011: expected training word on q_i, the 7:1 LVDS clock-lane pattern.
- SETTLE_CYC, 8: cycles to wait after start or after a slip before comparing. Range 1..255.
- MATCH_CYC, 16: consecutive matches required to declare lock. Range 1..255.
- MAX_SLIPS, 13: slips allowed before declaring failure. Range 1..15.
- CALIB_LEN, 1: width of each calib_o pulse, in cycles. Range 1..15.
- LOSS_THR, 4: consecutive mismatches while locked that cause re-alignment. Range 1..255.

Ports:
- clk  in  1  parallel clock (deserializer PCLK); all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request alignment; single-cycle pulse or level.
- q_i  in  7  deserializer parallel output, Q6..Q0.
- calib_o  out  1  drives the deserializer CALIB input; each pulse produces one bit slip.
- busy_o  out  1  high while an alignment is in progress.
- locked_o  out  1  high while aligned.
- fail_o  out  1  high after alignment fails; sticky.
- slip_cnt_o  out  4  number of slips issued in the current attempt.

## Operation
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- Reset value of every output is 0; reset puts the FSM in IDLE. All outputs are registered.
- start_i is sampled only in IDLE, LOCKED and FAIL. In any of those states, start_i=1 moves to SETTLE and clears slip_cnt_o, fail_o and locked_o. start_i is ignored in SETTLE, CHECK and SLIP.
- SETTLE:
  - busy_o=1.
  - Waits exactly SETTLE_CYC cycles, then moves to CHECK with the match counter cleared.
- CHECK, evaluated each cycle:
  - q_i==PATTERN: increment the match counter. When it reaches MATCH_CYC, move to LOCKED.
  - Mismatch with slip_cnt_o<MAX_SLIPS: move to SLIP.
  - Mismatch with slip_cnt_o==MAX_SLIPS: move to FAIL.
- SLIP:
  - calib_o=1 for exactly CALIB_LEN cycles.
  - slip_cnt_o increments once, on SLIP entry.
  - Then moves to SETTLE.
- LOCKED:
  - locked_o=1, busy_o=0, and slip_cnt_o holds its value.
  - A loss counter counts consecutive mismatches and is cleared by any match.
  - When the loss counter reaches LOSS_THR: locked_o=0, slip_cnt_o clears, and the FSM moves to SETTLE (automatic re-alignment).
- FAIL: fail_o=1 and busy_o=0. The FSM stays in FAIL until start_i or rst_i.
- Counter behaviour:
  - slip_cnt_o saturates at MAX_SLIPS and never wraps.
  - The settle, match and pulse counts share one 8-bit down-counter.
  - The loss counter is separate and saturating.
- Simultaneous events: rst_i overrides start_i. In LOCKED, start_i overrides loss detection in the same cycle.

## Timing
- Cycle 0 is the cycle in which start_i is sampled high.
  - SETTLE occupies cycles 1..SETTLE_CYC.
  - The first comparison happens at cycle SETTLE_CYC+1.
- Mismatch at CHECK cycle t: calib_o is high in cycles t+1..t+CALIB_LEN, and slip_cnt_o updates at t+1.
- Lock with no slips: locked_o rises at cycle SETTLE_CYC+MATCH_CYC+1, and busy_o falls in the same cycle.
- Each slip adds 1+CALIB_LEN+SETTLE_CYC cycles before the next comparison.
- Loss of lock: locked_o falls one cycle after the LOSS_THR-th consecutive mismatch, and busy_o rises in the same cycle.
- Reset in the middle of a calib_o pulse: calib_o is 0 in the cycle after rst_i is sampled high.

## Structure
- Shared package ivideo_align_pkg:
  - state enum (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL);
  - default PATTERN constant;
  - counter width constants (8-bit shared counter, 4-bit slip count).
- No sub-module; a single FSM and its counters in one module.
- The instantiating top connects calib_o to the deserializer CALIB input and q_i to Q0..Q6.

## Test plan
All scenarios use the default parameters.
- Aligned input:
  - Stimulus: q_i fixed at 7'b1100011, start_i pulsed at cycle 0.
  - Response: locked_o=1 at cycle 25, slip_cnt_o=0, calib_o never asserted.
- Misaligned by 3 bits:
  - Stimulus: the model rotates q_i by one bit per calib_o pulse.
  - Response: exactly 3 single-cycle calib_o pulses, then locked_o=1 with slip_cnt_o=3.
- Never aligns:
  - Stimulus: q_i held at 7'h00.
  - Response: 13 calib_o pulses, then fail_o=1, busy_o=0, slip_cnt_o=13. fail_o holds until start_i.
- Loss of lock:
  - Stimulus: while locked, inject 3 mismatches, then 1 match, then 4 mismatches.
  - Response: lock is held through the 3 mismatches. locked_o drops one cycle after the 4th consecutive mismatch, and busy_o=1.
- Reset mid-slip:
  - Stimulus: assert rst_i in the calib_o-high cycle.
  - Response: on the next cycle all outputs are 0 and the FSM is IDLE. start_i in SETTLE is ignored.
